// File: rtl/step_profile_ctrl.sv
// Trapezoidal-ramp step sequencer: exact step count, accel/cruise/decel,
// with an abort request that ramps down instead of stopping dead.
// Ports: clk, xres (sync, active-high), start, abort, dir_in, mode_in, steps
//        -> cnt_clk, cw, mode, busy, done, step_cnt (all registered).
module step_profile_ctrl #(
  parameter int PER_W   = 16,
  parameter int CNT_W   = 16,
  parameter int P_START = 2000,
  parameter int P_MIN   = 200,
  parameter int P_STEP  = 50,
  parameter int PULSE_W = 4
) (
  input  logic             clk,
  input  logic             xres,
  input  logic             start,
  input  logic             abort,
  input  logic             dir_in,
  input  logic [1:0]       mode_in,
  input  logic [CNT_W-1:0] steps,
  output logic             cnt_clk,
  output logic             cw,
  output logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] step_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEL  = 3'd1;
  localparam logic [2:0] S_CRUISE = 3'd2;
  localparam logic [2:0] S_DECEL  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [PER_W-1:0] PS  = PER_W'(P_START);
  localparam logic [PER_W-1:0] PM  = PER_W'(P_MIN);
  localparam logic [PER_W-1:0] PD  = PER_W'(P_STEP);
  localparam logic [PER_W-1:0] PW  = PER_W'(PULSE_W);
  localparam logic [PER_W-1:0] P1  = PER_W'(1);
  localparam logic [CNT_W-1:0] C1  = CNT_W'(1);

  logic [2:0]       state;
  logic [PER_W-1:0] per;
  logic [PER_W-1:0] ph;
  logic [CNT_W-1:0] ramp_cnt;
  logic [CNT_W-1:0] steps_l;
  logic             abort_l;

  logic [CNT_W-1:0] rem;
  logic             last;
  logic             ab;
  logic [PER_W:0]   up_w;
  logic [PER_W:0]   dn_lim;
  logic [PER_W-1:0] per_up;
  logic [PER_W-1:0] per_dn;
  logic [CNT_W-1:0] ramp_dn;
  logic [PER_W-1:0] ph_nx;

  always_comb begin
    rem     = steps_l - step_cnt;
    last    = (ph == per - P1);
    ab      = abort_l | abort;
    ph_nx   = ph + P1;
    // Widened by one bit so the clamps never see a wrapped value.
    up_w    = {1'b0, per} + {1'b0, PD};
    dn_lim  = {1'b0, PM} + {1'b0, PD};
    per_up  = (up_w >= {1'b0, PS}) ? PS : up_w[PER_W-1:0];
    per_dn  = ({1'b0, per} >= dn_lim) ? per - PD : PM;
    ramp_dn = (ramp_cnt == '0) ? '0 : ramp_cnt - C1;
  end

  always_ff @(posedge clk) begin
    if (xres) begin
      state    <= S_IDLE;
      per      <= PS;
      ph       <= '0;
      ramp_cnt <= '0;
      steps_l  <= '0;
      abort_l  <= 1'b0;
      cnt_clk  <= 1'b0;
      cw       <= 1'b0;
      mode     <= 2'b00;
      busy     <= 1'b0;
      done     <= 1'b0;
      step_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cw       <= dir_in;
            mode     <= mode_in;
            steps_l  <= steps;
            ramp_cnt <= '0;
            per      <= PS;
            ph       <= '0;
            abort_l  <= 1'b0;
            if (steps == '0) begin
              step_cnt <= '0;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              // First pulse goes out the very next cycle.
              step_cnt <= C1;
              cnt_clk  <= 1'b1;
              busy     <= 1'b1;
              state    <= S_ACCEL;
            end
          end
        end
        S_ACCEL, S_CRUISE, S_DECEL: begin
          if (abort && state != S_DECEL)
            abort_l <= 1'b1;
          if (!last) begin
            ph      <= ph_nx;
            cnt_clk <= (ph_nx < PW);
          end else if (rem == '0 ||
                       (state == S_DECEL && abort_l &&
                        ramp_cnt == '0)) begin
            cnt_clk <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            ph       <= '0;
            cnt_clk  <= 1'b1;
            step_cnt <= step_cnt + C1;
            // Entering DECEL already applies the first slow-down step.
            if (state != S_DECEL && (rem <= ramp_cnt || ab)) begin
              state    <= S_DECEL;
              per      <= per_up;
              ramp_cnt <= ramp_dn;
            end else if (state == S_ACCEL) begin
              per      <= per_dn;
              ramp_cnt <= ramp_cnt + C1;
              if (per_dn == PM)
                state <= S_CRUISE;
            end else if (state == S_DECEL) begin
              per      <= per_up;
              ramp_cnt <= ramp_dn;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_profile_ctrl.sv
// Self-checking bench for step_profile_ctrl: step-level profile model,
// directed test-plan moves plus randomized moves with abort/restart.
module tb_step_profile_ctrl;

  localparam int PS  = 10;
  localparam int PM  = 4;
  localparam int PST = 2;
  localparam int PW  = 2;

  logic        clk = 1'b0;
  logic        xres;
  logic        start;
  logic        abort;
  logic        dir_in;
  logic [1:0]  mode_in;
  logic [15:0] steps;
  logic        cnt_clk;
  logic        cw;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [15:0] step_cnt;

  step_profile_ctrl #(
    .PER_W(16), .CNT_W(16), .P_START(PS),
    .P_MIN(PM), .P_STEP(PST), .PULSE_W(PW)
  ) dut (
    .clk(clk), .xres(xres), .start(start), .abort(abort),
    .dir_in(dir_in), .mode_in(mode_in), .steps(steps),
    .cnt_clk(cnt_clk), .cw(cw), .mode(mode), .busy(busy),
    .done(done), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0d, want %0d", tag, cyc, got, exp);
    end
  endtask

  // Reference: step-by-step trapezoid. Produces rise cycles and done cycle.
  int rises[$];
  int done_at;

  task automatic model(input int t0, input int n, input int ab_at);
    int t, per, ramp, ph, last;
    bit ab;
    rises.delete();
    if (n == 0) begin
      done_at = t0 + 1;
      return;
    end
    t = t0 + 1; per = PS; ramp = 0; ph = 0; ab = 0;
    for (int k = 1; k <= 70000; k++) begin
      last = t + per - 1;
      rises.push_back(t);
      if (ph != 2 && ab_at >= t && ab_at <= last) ab = 1;
      if (n - k == 0 || (ph == 2 && ab && ramp == 0)) begin
        done_at = last + 1;
        return;
      end
      if (ph != 2 && (n - k <= ramp || ab)) begin
        ph = 2;
        per = (per + PST > PS) ? PS : per + PST;
        ramp = (ramp > 0) ? ramp - 1 : 0;
      end else if (ph == 0) begin
        per = (per - PST < PM) ? PM : per - PST;
        ramp++;
        if (per == PM) ph = 1;
      end else if (ph == 2) begin
        per = (per + PST > PS) ? PS : per + PST;
        ramp = (ramp > 0) ? ramp - 1 : 0;
      end
      t = last + 1;
    end
    done_at = t;
  endtask

  // Runs one move from the current negedge; checks every cycle to done+1.
  task automatic run_move(input int n, input logic d, input logic [1:0] m,
                          input int ab_off, input int rs_off,
                          output int t0, output int od);
    int ab_at, rs_at, ri, hi_end;
    t0 = cyc;
    ab_at = (ab_off < 0) ? -1 : t0 + 1 + ab_off;
    rs_at = (rs_off < 0) ? -1 : t0 + 1 + rs_off;
    model(t0, n, ab_at);
    start = 1'b1; dir_in = d; mode_in = m; steps = 16'(n); abort = 1'b0;
    od = -1;
    ri = 0;
    for (int c = t0 + 1; c <= done_at + 1; c++) begin
      @(negedge clk);
      while (ri < rises.size() && rises[ri] <= c) ri++;
      hi_end = (ri > 0) ? rises[ri-1] + PW : 0;
      chk("cnt_clk", int'(cnt_clk), int'(c < hi_end));
      chk("step_cnt", int'(step_cnt), ri);
      chk("busy", int'(busy), int'(c < done_at));
      chk("done", int'(done), int'(c == done_at));
      chk("cw", int'(cw), int'(d));
      chk("mode", int'(mode), int'(m));
      if (done && od < 0) od = c;
      if (c == rs_at && c < done_at) begin
        start = 1'b1; dir_in = ~d; mode_in = ~m; steps = 16'(n + 5);
      end else begin
        start = 1'b0; dir_in = d; mode_in = m; steps = 16'(n);
      end
      abort = (c == ab_at);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  int t0, od;

  initial begin
    xres = 1'b1; start = 1'b0; abort = 1'b0;
    dir_in = 1'b0; mode_in = 2'b00; steps = '0;
    repeat (3) @(negedge clk);
    chk("rst_cnt_clk", int'(cnt_clk), 0);
    chk("rst_cw", int'(cw), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_step_cnt", int'(step_cnt), 0);
    xres = 1'b0;
    @(negedge clk);

    run_move(6, 1'b1, 2'b01, -1, -1, t0, od);
    chk("s6_done_lat", od - t0, 43);
    chk("s6_steps", int'(step_cnt), 6);

    run_move(20, 1'b0, 2'b00, -1, -1, t0, od);
    chk("s20_steps", int'(step_cnt), 20);
    chk("s20_busy", int'(busy), 0);

    run_move(0, 1'b1, 2'b00, -1, -1, t0, od);
    chk("s0_done_lat", od - t0, 1);

    // Abort lands in the 7th step (cruise); DECEL gives steps 8..10.
    run_move(100, 1'b0, 2'b01, 36, -1, t0, od);
    chk("abort_lt", int'(step_cnt < 16'd100), 1);
    chk("abort_steps", int'(step_cnt), 10);

    run_move(20, 1'b1, 2'b01, -1, 5, t0, od);
    chk("restart_steps", int'(step_cnt), 20);

    // Reset in the middle of the first (accelerating) period.
    start = 1'b1; dir_in = 1'b1; mode_in = 2'b01; steps = 16'd30;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    xres = 1'b1;
    @(negedge clk);
    chk("xr_cnt_clk", int'(cnt_clk), 0);
    chk("xr_busy", int'(busy), 0);
    chk("xr_step_cnt", int'(step_cnt), 0);
    chk("xr_done", int'(done), 0);
    chk("xr_cw", int'(cw), 0);
    chk("xr_mode", int'(mode), 0);
    xres = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("xr_quiet", int'(cnt_clk | done | busy), 0);
    end
    run_move(6, 1'b0, 2'b01, -1, -1, t0, od);
    chk("xr_rerun_lat", od - t0, 43);

    for (int i = 0; i < 25; i++) begin
      int n, ab_off, rs_off;
      n = $urandom_range(0, 40);
      ab_off = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 200) : -1;
      rs_off = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 50) : -1;
      run_move(n, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)),
               ab_off, rs_off, t0, od);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
